// File: rtl/lpf_threshold_trigger.sv
// lpf_threshold_trigger: hysteretic, debounced threshold comparator on a sporadically
// updated filter output, with a holdoff-gated one-cycle trigger on each qualified rise.
module lpf_threshold_trigger #(
    parameter int HOLDOFF_W = 16,
    parameter int CONF_W    = 8
) (
    input  logic                 clock_in,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [27:0]          signal_in,
    input  logic [27:0]          thr_high,
    input  logic [27:0]          thr_low,
    input  logic [CONF_W-1:0]    confirm,
    input  logic [HOLDOFF_W-1:0] holdoff,
    output logic                 sample_valid,
    output logic                 level_out,
    output logic                 trig_pulse,
    output logic                 cfg_err,
    output logic [1:0]           state
);
    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_RISE = 2'd1,
        S_HIGH = 2'd2,
        S_FALL = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [27:0]           sig_q, sig_d;
    logic                  sv_q, sv_d;
    logic [CONF_W-1:0]     cnt_q, cnt_d;
    logic [HOLDOFF_W-1:0]  hold_q, hold_d;
    logic                  trig_q, trig_d;
    logic                  cfg_err_q, cfg_err_d;
    logic [CONF_W-1:0]     conf_eff, cnt_inc;
    logic                  above, below;

    always_comb begin
        conf_eff  = (confirm == '0) ? CONF_W'(1) : confirm;
        cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        above     = $signed(sig_q) > $signed(thr_high);
        below     = $signed(sig_q) < $signed(thr_low);
        sig_d     = sig_q;
        sv_d      = 1'b0;
        state_d   = state_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        trig_d    = 1'b0;
        cfg_err_d = $signed(thr_low) > $signed(thr_high);
        if (enable) begin
            sig_d  = signal_in;
            sv_d   = signal_in != sig_q;
            hold_d = (hold_q != '0) ? hold_q - 1'b1 : hold_q;
            if (cfg_err_q) begin
                state_d = S_LOW;
                cnt_d   = '0;
            end else if (sv_q) begin
                unique case (state_q)
                    S_LOW: if (above) begin
                        state_d = (conf_eff == CONF_W'(1)) ? S_HIGH : S_RISE;
                        cnt_d   = (conf_eff == CONF_W'(1)) ? '0 : CONF_W'(1);
                    end
                    S_RISE: begin
                        // >= lets a confirm lowered mid-pend finish on the next sample
                        state_d = !above ? S_LOW : (cnt_inc >= conf_eff) ? S_HIGH : S_RISE;
                        cnt_d   = (above && cnt_inc < conf_eff) ? cnt_inc : '0;
                    end
                    S_HIGH: if (below) begin
                        state_d = (conf_eff == CONF_W'(1)) ? S_LOW : S_FALL;
                        cnt_d   = (conf_eff == CONF_W'(1)) ? '0 : CONF_W'(1);
                    end
                    S_FALL: begin
                        state_d = !below ? S_HIGH : (cnt_inc >= conf_eff) ? S_LOW : S_FALL;
                        cnt_d   = (below && cnt_inc < conf_eff) ? cnt_inc : '0;
                    end
                endcase
            end
            if (!state_q[1] && state_d == S_HIGH && hold_q == '0) begin
                trig_d = 1'b1;
                hold_d = holdoff;
            end
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q   <= S_LOW;
            sig_q     <= '0;
            sv_q      <= 1'b0;
            cnt_q     <= '0;
            hold_q    <= '0;
            trig_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sig_q     <= sig_d;
            sv_q      <= sv_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            trig_q    <= trig_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign sample_valid = sv_q;
    assign level_out    = state_q[1] & ~cfg_err_q;
    assign trig_pulse   = trig_q;
    assign cfg_err      = cfg_err_q;
    assign state        = state_q;
endmodule

// File: tb/tb_lpf_threshold_trigger.sv
// tb_lpf_threshold_trigger: directed scenario tasks with hand-computed expectations.
module tb_lpf_threshold_trigger;
    logic        clock_in = 1'b0;
    logic        reset, enable;
    logic [27:0] signal_in, thr_high, thr_low;
    logic [7:0]  confirm;
    logic [15:0] holdoff;
    logic        sample_valid, level_out, trig_pulse, cfg_err;
    logic [1:0]  state;
    int          errors = 0;
    int          checks = 0;

    lpf_threshold_trigger dut (
        .clock_in(clock_in), .reset(reset), .enable(enable), .signal_in(signal_in),
        .thr_high(thr_high), .thr_low(thr_low), .confirm(confirm), .holdoff(holdoff),
        .sample_valid(sample_valid), .level_out(level_out), .trig_pulse(trig_pulse),
        .cfg_err(cfg_err), .state(state)
    );

    always #5 clock_in = ~clock_in;

    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; signal_in = '0; confirm = 8'd1; holdoff = '0;
        thr_high = 28'(1000); thr_low = 28'(-1000);
        tick(); tick();
        checks++; if ({sample_valid, level_out, trig_pulse, cfg_err, state} !== 6'b0) begin errors++; $display("FAIL reset_outputs: got %b expected 000000", {sample_valid, level_out, trig_pulse, cfg_err, state}); end
        reset = 1'b0;
        tick();
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_no_strobe_on_zero: got %b expected 0", sample_valid); end
    endtask

    task automatic test_basic();
        signal_in = 28'(2000);
        tick();
        checks++; if (sample_valid !== 1'b1 || level_out !== 1'b0) begin errors++; $display("FAIL basic_strobe: sv=%b lvl=%b expected sv=1 lvl=0", sample_valid, level_out); end
        tick();
        checks++; if (level_out !== 1'b1 || trig_pulse !== 1'b1 || state !== 2'd2) begin errors++; $display("FAIL basic_trigger: lvl=%b trig=%b st=%0d expected 1 1 2", level_out, trig_pulse, state); end
        tick();
        checks++; if (trig_pulse !== 1'b0 || sample_valid !== 1'b0 || level_out !== 1'b1) begin errors++; $display("FAIL basic_one_cycle: trig=%b sv=%b lvl=%b expected 0 0 1", trig_pulse, sample_valid, level_out); end
        signal_in = 28'(-2000);
        tick(); tick();
        checks++; if (state !== 2'd0 || level_out !== 1'b0) begin errors++; $display("FAIL basic_fall: st=%0d lvl=%b expected 0 0", state, level_out); end
    endtask

    task automatic test_debounce();
        int         s[6] = '{2000, 2001, 500, 2000, 2001, 2002};
        logic [1:0] e[6] = '{2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd2};
        confirm = 8'd3;
        for (int i = 0; i < 6; i++) begin
            signal_in = 28'(s[i]);
            tick(); tick();
            checks++; if (state !== e[i] || level_out !== (i == 5) || trig_pulse !== (i == 5)) begin errors++; $display("FAIL debounce_sample%0d: st=%0d lvl=%b trig=%b expected st=%0d lvl=trig=%0d", i, state, level_out, trig_pulse, e[i], i == 5); end
        end
    endtask

    task automatic test_hysteresis();
        int s[3] = '{0, -500, 999};
        confirm = 8'd1;
        for (int i = 0; i < 3; i++) begin
            signal_in = 28'(s[i]);
            tick(); tick();
            checks++; if (state !== 2'd2 || level_out !== 1'b1 || trig_pulse !== 1'b0) begin errors++; $display("FAIL hyst_hold%0d: st=%0d lvl=%b trig=%b expected 2 1 0", i, state, level_out, trig_pulse); end
        end
        signal_in = 28'(-1001);
        tick(); tick();
        checks++; if (state !== 2'd0 || level_out !== 1'b0 || trig_pulse !== 1'b0) begin errors++; $display("FAIL hyst_fall: st=%0d lvl=%b trig=%b expected 0 0 0", state, level_out, trig_pulse); end
    endtask

    task automatic test_holdoff();
        holdoff = 16'd20;
        signal_in = 28'(3000); tick(); tick();
        checks++; if (trig_pulse !== 1'b1 || level_out !== 1'b1) begin errors++; $display("FAIL holdoff_first: trig=%b lvl=%b expected 1 1", trig_pulse, level_out); end
        signal_in = 28'(-3000); tick(); tick();
        checks++; if (level_out !== 1'b0) begin errors++; $display("FAIL holdoff_fall: lvl=%b expected 0", level_out); end
        signal_in = 28'(3000); tick(); tick();
        checks++; if (trig_pulse !== 1'b0 || level_out !== 1'b1) begin errors++; $display("FAIL holdoff_suppressed: trig=%b lvl=%b expected 0 1", trig_pulse, level_out); end
        signal_in = 28'(-3000); tick(); tick();
        repeat (16) tick();
        signal_in = 28'(3000); tick(); tick();
        checks++; if (trig_pulse !== 1'b1 || level_out !== 1'b1) begin errors++; $display("FAIL holdoff_expired: trig=%b lvl=%b expected 1 1", trig_pulse, level_out); end
        tick();
        checks++; if (trig_pulse !== 1'b0) begin errors++; $display("FAIL holdoff_pulse_width: trig=%b expected 0", trig_pulse); end
    endtask

    task automatic test_cfg_err_reset();
        thr_low = 28'(5000); thr_high = 28'(1000); signal_in = 28'(9000);
        tick();
        checks++; if (cfg_err !== 1'b1 || level_out !== 1'b0) begin errors++; $display("FAIL cfg_flag: cfg=%b lvl=%b expected 1 0", cfg_err, level_out); end
        tick();
        checks++; if (state !== 2'd0 || level_out !== 1'b0 || trig_pulse !== 1'b0) begin errors++; $display("FAIL cfg_forced_low: st=%0d lvl=%b trig=%b expected 0 0 0", state, level_out, trig_pulse); end
        thr_low = 28'(-1000); confirm = 8'd3;
        tick();
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_clear: cfg=%b expected 0", cfg_err); end
        signal_in = 28'(9001); tick(); tick();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL rise_pend: st=%0d expected 1", state); end
        reset = 1'b1; tick();
        checks++; if ({sample_valid, level_out, trig_pulse, cfg_err, state} !== 6'b0) begin errors++; $display("FAIL reset_abort: got %b expected 000000", {sample_valid, level_out, trig_pulse, cfg_err, state}); end
        reset = 1'b0; tick();
        checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL post_reset_strobe: sv=%b expected 1", sample_valid); end
        tick();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL post_reset_pend: st=%0d expected 1", state); end
    endtask

    task automatic test_enable_freeze();
        int strobes = 0;
        signal_in = 28'(100); tick(); tick(); tick();
        checks++; if (state !== 2'd0 || sample_valid !== 1'b0) begin errors++; $display("FAIL freeze_setup: st=%0d sv=%b expected 0 0", state, sample_valid); end
        enable = 1'b0; signal_in = 28'(200);
        for (int i = 0; i < 3; i++) begin tick(); strobes += int'(sample_valid); end
        checks++; if (strobes != 0 || state !== 2'd0) begin errors++; $display("FAIL freeze_no_strobe: strobes=%0d st=%0d expected 0 0", strobes, state); end
        enable = 1'b1; tick();
        checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL freeze_resume_strobe: sv=%b expected 1", sample_valid); end
        tick();
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL freeze_single_strobe: sv=%b expected 0", sample_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_debounce();
        test_hysteresis();
        test_holdoff();
        test_cfg_err_reset();
        test_enable_freeze();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
